m_receiver: RTL
===============

Name: m_receiver

Overview:
- Manchester line receiver; the downstream counterpart of m_transmitter. Consumes the serial o_tx line.
- Recovers bit timing from mid-bit transitions, finds the frame sync byte and reads the length byte.
- Delivers payload bytes on a strobe interface, plus frame-level status and a frame counter.
- Single clock domain. The rx line is asynchronous and is synchronised internally.

Parameters:
- BIT_CLKS, 8, i_clk cycles per Manchester bit period; even, >= 4.
- SYNC_BYTE, 8'hD5, frame delimiter byte, received LSB first.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  synchronous reset, active-high.
- i_rx  in  1  serial Manchester line; idles high.
- o_data  out  8  received payload byte; valid only while o_data_valid=1.
- o_data_valid  out  1  one-cycle strobe per payload byte.
- o_frame_start  out  1  one-cycle strobe when the length byte is accepted.
- o_frame_done  out  1  one-cycle strobe when the last payload byte is delivered.
- o_frame_err  out  1  one-cycle strobe on a timing loss inside LEN or DATA.
- o_frame_len  out  8  length byte of the current or last frame.
- o_frames_count  out  8  count of good frames; wraps 255->0.
- o_status  out  8  {busy, 3'b0, state[3:0]}; busy=1 when state != IDLE.

Behaviour:
- Reset is synchronous and active-high (i_rst=1 at a rising edge of i_clk). It dominates every other input.
- Reset values: all outputs 0, state=IDLE, synchroniser flops=1. Reset mid-frame discards the frame with no strobes.
- Synchroniser: i_rx passes through 2 flops, then an edge-detect register. Sampled-line latency is 3 cycles.
- Encoding (IEEE 802.3): mid-bit rising edge = 1, mid-bit falling edge = 0. Bits are LSB first.
- Bit timer: a counter cleared on every accepted mid-bit edge.
  - Edges with counter < 3*BIT_CLKS/4 are bit-boundary edges and are ignored.
  - The first edge with counter >= 3*BIT_CLKS/4 is a mid-bit edge: its data bit is shifted in and the counter clears.
  - Counter reaching 5*BIT_CLKS/4 is a timeout.
- State IDLE: the first edge of either polarity is taken as a mid-bit edge. Its bit is shifted into an 8-bit hunt register; go to SYNC.
- State SYNC: shift each bit into the hunt register.
  - Hunt register == SYNC_BYTE: clear the bit count and go to LEN.
  - Timeout: go to IDLE silently.
- State LEN: collect 8 bits.
  - Value 0: go to IDLE; no strobes, not counted.
  - Otherwise: latch o_frame_len, pulse o_frame_start, load remaining=value, go to DATA.
- State DATA: after every 8th bit, o_data=byte, o_data_valid=1 for one cycle, remaining--.
  - When remaining reaches 0, pulse o_frame_done in the same cycle as the final o_data_valid.
  - In that same cycle, increment o_frames_count and go to IDLE.
- Timeout in LEN or DATA: pulse o_frame_err, go to IDLE. Bytes already delivered stand; the counter does not increment.
- Byte delivery latency: o_data_valid rises in the cycle after the sampled mid-bit edge of bit 7.
- Trailing edges after DONE are seen from IDLE. They restart sync hunting. A frame is recognised only by a full SYNC_BYTE match.
- Strobes never overlap across frames; o_frame_err and o_frame_done are mutually exclusive.

Test Plan:
1. Send sync 0xD5, length 0x03, bytes 0x01,0x00,0xF4 at BIT_CLKS=8:
   - 3 o_data_valid strobes with o_data=0x01,0x00,0xF4;
   - o_frame_start once and o_frame_len=3;
   - o_frame_done with the 0xF4 strobe;
   - o_frames_count=1, then o_status busy=0.
2. Two 1-byte frames back-to-back (0xAA then 0x55) with 2 idle bit periods between:
   - o_frames_count=2;
   - data strobes 0xAA, 0x55 in order.
3. Frame with length 0x02, line held high after the first payload byte:
   - one data strobe;
   - o_frame_err pulse 10 clocks after the last mid-bit edge;
   - no o_frame_done; o_frames_count unchanged.
4. Length 0x00 after sync: no strobes of any kind, counter unchanged, returns to IDLE.
5. Assert i_rst for 1 cycle in the middle of a 4-byte payload (after byte 2):
   - all outputs 0 the next cycle and no further strobes;
   - a following good frame decodes correctly.
6. Preload 255 good frames, send one more: o_frames_count wraps to 0x00 with o_frame_done asserted.

Source files
------------

// File: rtl/m_receiver.sv
// m_receiver: Manchester line receiver with bit-timing recovery, sync hunt, length byte and payload strobes
module m_receiver #(
  parameter int BIT_CLKS = 8,
  parameter logic [7:0] SYNC_BYTE = 8'hD5
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_data_valid,
  output logic       o_frame_start,
  output logic       o_frame_done,
  output logic       o_frame_err,
  output logic [7:0] o_frame_len,
  output logic [7:0] o_frames_count,
  output logic [7:0] o_status
);
  localparam int TO = 5 * BIT_CLKS / 4;
  localparam int CW = $clog2(TO + 1);
  localparam logic [CW-1:0] MID_C = CW'(3 * BIT_CLKS / 4);
  localparam logic [CW-1:0] TO_C = CW'(TO);
  typedef enum logic [3:0] {IDLE, SYNC, LEN, DATA} state_t;
  state_t state, state_n;
  logic s1, s2, s3, edg, acc, tout, in_frame, byte_end, start, dv, last;
  logic [CW-1:0] cnt;
  logic [7:0] sh, sh_n, rem;
  logic [2:0] nb;
  always_comb begin
    in_frame = state == LEN || state == DATA;
    edg = s2 != s3;
    tout = state != IDLE && cnt == TO_C;
    acc = edg && !tout && (state == IDLE || cnt >= MID_C);
    sh_n = state == IDLE ? {s2, 7'b0} : {s2, sh[7:1]};
    byte_end = acc && in_frame && nb == 3'd7;
    start = byte_end && state == LEN && sh_n != 8'd0;
    dv = byte_end && state == DATA;
    last = dv && rem == 8'd1;
    state_n = tout ? IDLE :
              !acc ? state :
              state == IDLE ? SYNC :
              state == SYNC ? (sh_n == SYNC_BYTE ? LEN : SYNC) :
              state == LEN ? (nb != 3'd7 ? LEN : start ? DATA : IDLE) :
              last ? IDLE : DATA;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      {s1, s2, s3} <= 3'b111;
      state <= IDLE;
      cnt <= '0;
      sh <= '0;
      rem <= '0;
      nb <= '0;
      o_data <= '0;
      o_data_valid <= 1'b0;
      o_frame_start <= 1'b0;
      o_frame_done <= 1'b0;
      o_frame_err <= 1'b0;
      o_frame_len <= '0;
      o_frames_count <= '0;
    end else begin
      {s1, s2, s3} <= {i_rx, s1, s2};
      state <= state_n;
      cnt <= acc ? '0 : cnt == TO_C ? cnt : cnt + 1'b1;
      sh <= acc ? sh_n : sh;
      nb <= in_frame ? nb + {2'b0, acc} : '0;
      rem <= start ? sh_n : dv ? rem - 8'd1 : rem;
      o_data <= dv ? sh_n : o_data;
      o_data_valid <= dv;
      o_frame_start <= start;
      o_frame_done <= last;
      o_frame_err <= tout && in_frame;
      o_frame_len <= start ? sh_n : o_frame_len;
      o_frames_count <= o_frames_count + {7'b0, last};
    end
  end
  assign o_status = {state != IDLE, 3'b0, state};
endmodule
